// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path.
//   sw_state_e        : controller state encoding, also driven out on the state port
//   TICK_DIV_DEFAULT  : system clock cycles per counted second
//   is_counting()     : true in the states where seconds advance
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

  // RUN and LAP are the only encodings with bit 0 set.
  function automatic logic is_counting(input sw_state_e s);
    return s[0];
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button / datapath bundle of the stopwatch controller.
//   btn_start_stop, btn_reset, btn_lap : debounced button levels into the controller
//   tick_en    : one-cycle count enable to the seconds counter
//   cnt_clr    : one-cycle synchronous clear to the seconds counter
//   lap_freeze : display hold level
//   running    : high while counting (RUN or LAP)
//   state      : current controller state
// master = controller side, slave = buttons/datapath side.
// Handshake: none; buttons are plain levels sampled every rising edge, and
// tick_en/cnt_clr are single-cycle strobes that the consumer must act on in
// the cycle they are high (there is no ready/back-pressure).
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;

  logic      btn_start_stop;
  logic      btn_reset;
  logic      btn_lap;
  logic      tick_en;
  logic      cnt_clr;
  logic      lap_freeze;
  logic      running;
  sw_state_e state;

  modport master (
    input  btn_start_stop, btn_reset, btn_lap,
    output tick_en, cnt_clr, lap_freeze, running, state
  );

  modport slave (
    output btn_start_stop, btn_reset, btn_lap,
    input  tick_en, cnt_clr, lap_freeze, running, state
  );

endinterface

// File: rtl/tick_prescaler.sv
// Per-second prescaler: counts 0..TICK_DIV-1 while run is high, holds
// otherwise, and is forced to 0 by clr.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the count (state is RUN or LAP)
//   clr        : accepted reset event; clears the count and masks tick
//   tick       : one-cycle count enable, high while counting at TICK_DIV-1
// TICK_DIV must be 2 or greater.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A reset event in the tick cycle wins: the counter is about to be
  // cleared, so it must not also increment.
  assign tick = run & at_last & ~clr;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge detection, IDLE/RUN/PAUSE/LAP
// state machine, per-second tick generation and counter clear strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   sw         : stopwatch_ctrl_if.master (buttons in; tick_en, cnt_clr,
//                lap_freeze, running, state out)
// Simultaneous button events resolve as reset > start_stop > lap.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.master sw
);

  // Previous button levels, order {reset, start_stop, lap}. They reset to 1
  // so a button already held when rst_n releases does not look like a press.
  logic [2:0] btn_prev_q;
  logic [2:0] btn_now;
  logic [2:0] btn_ev;
  logic       ev_reset;
  logic       ev_ss;
  logic       ev_lap;

  sw_state_e  state_q;
  sw_state_e  state_d;
  logic       cnt_clr_q;
  logic       tick;

  assign btn_now  = {sw.btn_reset, sw.btn_start_stop, sw.btn_lap};
  assign btn_ev   = btn_now & ~btn_prev_q;
  assign ev_reset = btn_ev[2];
  assign ev_ss    = btn_ev[1];
  assign ev_lap   = btn_ev[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 3'b111;
      cnt_clr_q  <= 1'b0;
    end else begin
      btn_prev_q <= btn_now;
      cnt_clr_q  <= ev_reset;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the if/else chain encodes event priority.
  always_comb begin
    state_d = state_q;
    if (ev_reset) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ev_ss) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (ev_ss)       state_d = ST_PAUSE;
          else if (ev_lap) state_d = ST_LAP;
        end
        ST_LAP: begin
          if (ev_ss)       state_d = ST_PAUSE;
          else if (ev_lap) state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (ev_ss) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The prescaler keeps running across RUN<->LAP and holds in PAUSE, so a
  // partial second survives both.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (is_counting(state_q)),
    .clr   (ev_reset),
    .tick  (tick)
  );

  // Output logic
  always_comb begin
    sw.tick_en    = tick;
    sw.cnt_clr    = cnt_clr_q;
    sw.lap_freeze = (state_q == ST_LAP);
    sw.running    = is_counting(state_q);
    sw.state      = state_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4. Buttons change 2 ns after a
// rising edge; a behavioural model pushes the expected output word for each
// cycle at the falling edge and a monitor pops and compares 1 ns later.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TD = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV (TD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Output word: {state[1:0], tick_en, cnt_clr, lap_freeze, running}
  logic [5:0] exp_q[$];

  // ---------------- reference model ----------------
  // Mode names are the state encodings fixed for the state port.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int m_mode    = M_IDLE;
  int m_elapsed = 0;   // cycles of counting time since the last whole second
  bit m_clr     = 0;
  bit m_prev_rs = 1, m_prev_ss = 1, m_prev_lp = 1;
  int m_secs    = 0;   // total seconds the counter should hold
  int dut_secs  = 0;   // seconds accumulated from the DUT strobes

  function automatic bit m_counting(input int mode);
    return (mode == M_RUN) || (mode == M_LAP);
  endfunction

  function automatic bit m_tick_now();
    bit rs;
    rs = sw_if.btn_reset && !m_prev_rs;
    return m_counting(m_mode) && (m_elapsed == TD - 1) && !rs;
  endfunction

  always @(negedge clk) begin
    logic [1:0] st;
    if (!rst_n) begin
      m_mode = M_IDLE; m_elapsed = 0; m_clr = 0;
      m_prev_rs = 1; m_prev_ss = 1; m_prev_lp = 1;
      m_secs = 0;
      exp_q.push_back(6'b0);
    end else begin
      st = 2'(m_mode);
      exp_q.push_back({st, m_tick_now(), m_clr, (m_mode == M_LAP), m_counting(m_mode)});
    end
  end

  always @(posedge clk) begin
    bit rs, ss, lp, tk;
    if (rst_n) begin
      rs = sw_if.btn_reset && !m_prev_rs;
      ss = sw_if.btn_start_stop && !m_prev_ss;
      lp = sw_if.btn_lap && !m_prev_lp;
      tk = m_tick_now();
      if (tk) m_secs = m_secs + 1;
      m_clr = rs;
      if (rs) begin
        m_mode = M_IDLE; m_elapsed = 0; m_secs = 0;
      end else begin
        if (m_counting(m_mode)) m_elapsed = (m_elapsed + 1) % TD;
        case (m_mode)
          M_IDLE:  if (ss) m_mode = M_RUN;
          M_RUN:   if (ss) m_mode = M_PAUSE; else if (lp) m_mode = M_LAP;
          M_LAP:   if (ss) m_mode = M_PAUSE; else if (lp) m_mode = M_RUN;
          M_PAUSE: if (ss) m_mode = M_RUN;
          default: m_mode = M_IDLE;
        endcase
      end
      m_prev_rs = sw_if.btn_reset;
      m_prev_ss = sw_if.btn_start_stop;
      m_prev_lp = sw_if.btn_lap;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [5:0] got, exp;
    @(negedge clk);
    #1;
    got = {sw_if.state, sw_if.tick_en, sw_if.cnt_clr, sw_if.lap_freeze, sw_if.running};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_underflow t=%0t got=%b", $time, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got {st,tick,clr,frz,run}=%b expected=%b", $time, got, exp);
      end
    end
    // Seconds counter as the datapath would see it.
    if (!rst_n)               dut_secs = 0;
    else if (sw_if.cnt_clr)   dut_secs = 0;
    else if (sw_if.tick_en)   dut_secs++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // mask = {reset, start_stop, lap}; high for one cycle, then low.
  task automatic press(input logic [2:0] mask);
    @(posedge clk); #2;
    {sw_if.btn_reset, sw_if.btn_start_stop, sw_if.btn_lap} = mask;
    @(posedge clk); #2;
    {sw_if.btn_reset, sw_if.btn_start_stop, sw_if.btn_lap} = 3'b000;
  endtask

  task automatic async_reset(input int hold);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {27'd0, sw_if.state, sw_if.tick_en, sw_if.cnt_clr, sw_if.lap_freeze, sw_if.running}, 32'd0);
    wait_cyc(hold);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  localparam logic [2:0] B_RS = 3'b100, B_SS = 3'b010, B_LP = 3'b001;

  // ---------------- stimulus ----------------
  initial begin
    sw_if.btn_reset = 0; sw_if.btn_start_stop = 0; sw_if.btn_lap = 0;
    #1;
    check("reset_state", {30'd0, sw_if.state}, 32'd0);
    wait_cyc(3);
    @(posedge clk); #2; rst_n = 1'b1;
    wait_cyc(2);

    // Start and count past a minute.
    press(B_SS);
    wait_cyc(250);
    check("seconds_wrap", dut_secs % 60, m_secs % 60);
    check("minutes_roll", dut_secs / 60, 1);

    // Pause mid-second, hold, resume.
    press(B_SS);
    wait_cyc(10);
    press(B_SS);
    wait_cyc(9);

    // Lap in, lap out, lap then start_stop into PAUSE.
    press(B_LP); wait_cyc(7);
    press(B_LP); wait_cyc(5);
    press(B_LP); wait_cyc(3);
    press(B_SS); wait_cyc(4);
    check("pause_from_lap_freeze", {31'd0, sw_if.lap_freeze}, 32'd0);
    check("pause_from_lap_state", {30'd0, sw_if.state}, 32'(ST_PAUSE));

    // Reset and start_stop together while running.
    press(B_SS); wait_cyc(3);
    press(B_RS | B_SS); wait_cyc(3);
    check("sim_reset_state", {30'd0, sw_if.state}, 32'(ST_IDLE));

    // Reset landing on the tick cycle.
    press(B_SS); wait_cyc(2);
    press(B_RS); wait_cyc(2);
    check("reset_on_tick_secs", dut_secs, 0);

    // Async reset mid-count, then release with start_stop held.
    press(B_SS); wait_cyc(6);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sw_if.btn_start_stop = 1'b1;
    #1;
    check("async_reset_running", {31'd0, sw_if.running}, 32'd0);
    wait_cyc(2);
    @(posedge clk); #2; rst_n = 1'b1;
    wait_cyc(5);
    check("held_through_reset", {30'd0, sw_if.state}, 32'(ST_IDLE));
    @(posedge clk); #2; sw_if.btn_start_stop = 1'b0;
    wait_cyc(2);

    // Random button traffic with occasional async resets.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [2:0] m;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset($urandom_range(0, 3));
      end else begin
        m = 3'($urandom_range(1, 7));
        if (r < 60) m = m & 3'b011;  // keep reset events rarer
        if (m == 3'b000) m = B_SS;
        press(m);
      end
      wait_cyc($urandom_range(0, 8));
    end

    wait_cyc(4);
    check("final_seconds", dut_secs, m_secs);
    @(negedge clk); #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
